// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, addresses the one-cycle-latency ROM and pairs
// its data with the matching PC for decode. Supports stall, redirect, halt/resume and a counter.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INST = 32'h0000_006F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        resume,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        halted,
    output logic [31:0] fetch_cnt,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic [31:0] target;
    logic        misaligned;

    assign target     = {redirect_pc[31:2], 2'b00};
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_f_q  <= RESET_PC;
            pc_d_q  <= RESET_PC;
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
            pc_d_q  <= pc_d_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_f_d  = pc_f_q;
        pc_d_d  = pc_d_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;

        // Redirect-cycle instructions still count; squashing them is downstream's job.
        if (inst_valid && !stall) begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            StBoot: begin
                pc_d_d  = pc_f_q;
                pc_f_d  = pc_f_q + 32'd4;
                state_d = StRun;
            end
            StRun: begin
                if (redirect) begin
                    pc_d_d = target;
                    pc_f_d = target + 32'd4;
                    mis_d  = mis_q | misaligned;
                end else if (!stall) begin
                    // PCs freeze on halt so resume re-fetches from halt PC + 4.
                    if (inst == HALT_INST) begin
                        state_d = StHalt;
                    end else begin
                        pc_d_d = pc_f_q;
                        pc_f_d = pc_f_q + 32'd4;
                    end
                end
            end
            StHalt: begin
                if (redirect) begin
                    pc_d_d  = target;
                    pc_f_d  = target + 32'd4;
                    mis_d   = mis_q | misaligned;
                    state_d = StRun;
                end else if (resume) begin
                    pc_d_d  = pc_f_q;
                    pc_f_d  = pc_f_q + 32'd4;
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        inst_valid   = (state_q == StRun);
        halted       = (state_q == StHalt);
        inst         = inst_valid ? imem_dout : NOP;
        inst_pc      = pc_d_q;
        fetch_cnt    = cnt_q;
        misalign_err = mis_q;

        // Stall re-reads the held word so no instruction hold register is needed.
        imem_addr = pc_f_q[15:2];
        if (state_q != StBoot) begin
            if (redirect) begin
                imem_addr = target[15:2];
            end else if (state_q == StRun && stall) begin
                imem_addr = pc_d_q[15:2];
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: each step queues the expected decode-side view and the
// post-edge sample is popped and checked with immediate assertions.
module tb_ifetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, resume;
    logic [31:0] redirect_pc;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] inst, inst_pc, fetch_cnt;
    logic        inst_valid, halted, misalign_err;

    logic [31:0] mem [0:16383];

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halted;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    ifetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .resume       (resume),
        .imem_addr    (imem_addr),
        .imem_dout    (imem_dout),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .halted       (halted),
        .fetch_cnt    (fetch_cnt),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_dout <= mem[imem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic h, input logic [31:0] cnt, input logic mis);
        exp_t e;
        e.valid  = v;
        e.pc     = pc;
        e.inst   = ins;
        e.halted = h;
        e.cnt    = cnt;
        e.mis    = mis;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic rs, input exp_t e);
        exp_t got;
        @(negedge clk);
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        resume      = rs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, got.valid});
        chk("inst_pc", inst_pc, got.pc);
        chk("inst", inst, got.inst);
        chk("halted", {31'd0, halted}, {31'd0, got.halted});
        chk("fetch_cnt", fetch_cnt, got.cnt);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, got.mis});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = i;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; resume = 1'b0;

        // Reset, BOOT, then streaming
        step(1, 0, 0, 0, 0, mk(0, 32'h0, NOP, 0, 0, 0));
        chk("imem_addr_rst", {18'd0, imem_addr}, 32'd0);
        step(0, 0, 0, 0, 0, mk(1, 32'h0, 32'd0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(1, 32'h4, 32'd1, 0, 1, 0));
        step(0, 0, 0, 0, 0, mk(1, 32'h8, 32'd2, 0, 2, 0));

        // Stall three cycles on pc 8
        step(0, 1, 0, 0, 0, mk(1, 32'h8, 32'd2, 0, 2, 0));
        step(0, 1, 0, 0, 0, mk(1, 32'h8, 32'd2, 0, 2, 0));
        step(0, 1, 0, 0, 0, mk(1, 32'h8, 32'd2, 0, 2, 0));
        step(0, 0, 0, 0, 0, mk(1, 32'hC, 32'd3, 0, 3, 0));

        // Redirect during stall, then misaligned redirect
        step(0, 1, 1, 32'h40, 0, mk(1, 32'h40, 32'd16, 0, 3, 0));
        step(0, 0, 0, 0, 0, mk(1, 32'h44, 32'd17, 0, 4, 0));
        step(0, 0, 1, 32'h42, 0, mk(1, 32'h40, 32'd16, 0, 5, 1));
        step(0, 0, 0, 0, 0, mk(1, 32'h44, 32'd17, 0, 6, 1));

        // Halt at 0x10: delivered once, five halted cycles (stall ignored), then resume
        mem[4] = HALT;
        step(0, 0, 1, 32'h10, 0, mk(1, 32'h10, HALT, 0, 7, 1));
        step(0, 0, 0, 0, 0, mk(0, 32'h10, NOP, 1, 8, 1));
        step(0, 1, 0, 0, 0, mk(0, 32'h10, NOP, 1, 8, 1));
        step(0, 0, 0, 0, 0, mk(0, 32'h10, NOP, 1, 8, 1));
        step(0, 1, 0, 0, 0, mk(0, 32'h10, NOP, 1, 8, 1));
        step(0, 0, 0, 0, 0, mk(0, 32'h10, NOP, 1, 8, 1));
        step(0, 0, 0, 0, 1, mk(1, 32'h14, 32'd5, 0, 8, 1));
        step(0, 0, 0, 0, 0, mk(1, 32'h18, 32'd6, 0, 9, 1));

        // Halt again, then reset out of HALT with other inputs active
        step(0, 0, 1, 32'h10, 0, mk(1, 32'h10, HALT, 0, 10, 1));
        step(0, 0, 0, 0, 0, mk(0, 32'h10, NOP, 1, 11, 1));
        step(1, 1, 1, 32'h81, 1, mk(0, 32'h0, NOP, 0, 0, 0));
        chk("imem_addr_rst2", {18'd0, imem_addr}, 32'd0);
        step(0, 0, 0, 0, 0, mk(1, 32'h0, 32'd0, 0, 0, 0));
        step(0, 0, 0, 0, 0, mk(1, 32'h4, 32'd1, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM wrapper. It owns the fetch PC, drives the ROM word address, and pairs the ROM's one-cycle-latency output with its PC. It presents a valid instruction/PC pair to decode, and supports stall, redirect (branch/jump), halt-on-instruction with resume, and an accepted-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction fetched after reset
- HALT_INST, 32'h0000_006F (jal x0,0), encoding that halts fetch once accepted

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset: synchronous, active-high; priority over every other input
- stall  in  1  downstream cannot accept; hold the current instruction
- redirect  in  1  take redirect_pc as the next fetch target
- redirect_pc  in  32  redirect target byte address
- resume  in  1  leave HALT and continue at halt PC + 4
- imem_addr  out  14  ROM word address (byte address bits [15:2])
- imem_dout  in  32  ROM data; equals mem[address sampled at previous edge]
- inst  out  32  instruction to decode
- inst_pc  out  32  byte PC of inst
- inst_valid  out  1  inst/inst_pc are meaningful this cycle
- halted  out  1  fetch is in HALT
- fetch_cnt  out  32  accepted-instruction count
- misalign_err  out  1  sticky: a redirect had redirect_pc[1:0] != 0

## Operation
- Registers: pc_f (next PC to send), pc_d (PC whose data is on imem_dout), state, fetch_cnt, misalign_err. inst_valid is 1 only in RUN; inst_pc = pc_d.
- inst = imem_dout when inst_valid, else 32'h0000_0013 (NOP).
- Redirect target t = {redirect_pc[31:2], 2'b00}. If redirect_pc[1:0] != 0, set misalign_err; it clears only on rst.
- States: BOOT, RUN, HALT.
- BOOT: entered on rst; lasts exactly one cycle; imem_addr = pc_f[15:2]. Next edge: pc_d <= pc_f, pc_f <= pc_f + 4, go RUN. Inputs are ignored.
- RUN, imem_addr select in priority order:
  - redirect: t[15:2]
  - stall: pc_d[15:2], so the ROM re-reads the held instruction and no hold register is needed
  - otherwise: pc_f[15:2]
- RUN edge updates:
  - redirect (wins over stall): pc_d <= t, pc_f <= t + 4
  - stall: pc_d and pc_f hold
  - otherwise: pc_d <= pc_f, pc_f <= pc_f + 4
- HALT entry: at a RUN edge with stall=0, redirect=0 and inst == HALT_INST, go HALT. The halt instruction is delivered exactly once.
- HALT: imem_addr = pc_f[15:2]; pc_f and pc_d hold; stall is ignored.
  - redirect: same update as in RUN, go RUN
  - else resume: pc_d <= pc_f, pc_f <= pc_f + 4, go RUN
- fetch_cnt increments at every edge with inst_valid=1 and stall=0, regardless of redirect. It wraps modulo 2^32.
- PC arithmetic is 32-bit modulo 2^32. Only bits [15:2] reach the ROM, so fetch wraps within 64 KiB.
- The inst shown during a redirect cycle is still counted as accepted. Squashing it is the downstream's job.

## Timing
- On a rst edge: state=BOOT, pc_f=pc_d=RESET_PC, fetch_cnt=0, misalign_err=0.
  - Resulting outputs: inst_valid=0, halted=0, inst=NOP, inst_pc=RESET_PC, imem_addr=RESET_PC[15:2].
- A rst asserted mid-operation takes effect at that edge, whatever the state or the other inputs.
- First valid instruction: the second edge after rst deasserts (BOOT, then RUN). inst_pc=RESET_PC.
- Throughput is 1 instruction per cycle with no stall.
- Redirect is zero-bubble: the instruction at t is valid the cycle after the redirect edge.
- Stall release: the held instruction is accepted at the release edge, and pc_f's instruction appears next cycle.
- Resume: the instruction at halt PC + 4 is valid one cycle after the resume edge.
- halted = (state == HALT) and is registered.

## Test plan
- Reset, ROM word n = n, no stall → inst_valid rises on cycle 2; inst_pc 0,4,8,… with inst 0,1,2,…; fetch_cnt=3 after 3 accepts.
- Stall high for 3 cycles while inst_pc=8 → inst_pc=8, inst=2 held all 3 cycles with fetch_cnt frozen; next cycle inst_pc=12.
- Redirect to 0x40 with stall also high → next cycle inst_pc=0x40 and inst=16, then 0x44; misalign_err stays 0.
- Redirect to 0x42 → inst_pc=0x40, misalign_err=1 and stays 1 until rst.
- HALT_INST at 0x10 → delivered once, then halted=1 and inst_valid=0 for 5 cycles; resume → inst_pc=0x14 valid one cycle later, halted=0.
- rst asserted while in HALT with misalign_err=1 → next cycle all reset values; first valid inst_pc=RESET_PC two edges after release.
